// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N output-stationary systolic array: holds A and B,
// then streams skewed rows of A into the left edge and columns of B into the top edge.
module systolic_feeder #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_WIDTH  = 8,
  localparam int IW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    wr_en,
  input  logic                                    wr_sel,
  input  logic [IW-1:0]                           wr_row,
  input  logic [IW-1:0]                           wr_col,
  input  logic [DATA_WIDTH-1:0]                   wr_data,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    arr_clr,
  output logic                                    arr_en,
  output logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0]  in_left,
  output logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0]  in_top
);

  localparam int N  = MATRIX_SIZE;
  localparam int TW = $clog2(3 * N);
  localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t                          state_reg, state_next;
  logic [TW-1:0]                   t_reg, t_next;
  logic                            busy_reg, busy_next;
  logic                            done_reg, done_next;
  logic                            clr_reg, clr_next;
  logic                            en_reg, en_next;
  logic [N-1:0][DATA_WIDTH-1:0]    left_reg, left_next;
  logic [N-1:0][DATA_WIDTH-1:0]    top_reg, top_next;
  logic [DATA_WIDTH-1:0]           a_mem [N][N];
  logic [DATA_WIDTH-1:0]           b_mem [N][N];
  logic                            wr_ok;
  logic                            feed_next;

  // Buffers are only writable while idle so a pass always sees a stable operand set.
  assign wr_ok = wr_en && (state_reg == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (wr_sel) begin
        b_mem[wr_row][wr_col] <= wr_data;
      end else begin
        a_mem[wr_row][wr_col] <= wr_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        state_next = FEED;
        t_next     = '0;
      end
      FEED: begin
        if (t_reg == T_LAST) begin
          state_next = DONE;
          t_next     = '0;
        end else begin
          t_next = t_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        t_next     = '0;
      end
    endcase

    busy_next = (state_next == CLEAR) || (state_next == FEED);
    done_next = (state_next == DONE);
    clr_next  = (state_next == CLEAR);
    en_next   = (state_next == FEED);
  end

  assign feed_next = (state_next == FEED);

  // Lane gi is delayed by gi cycles so A[i][k] and B[k][j] meet in PE[i][j] at t = i+j+k.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [IW-1:0] k_idx;
    logic          in_win;

    assign k_idx  = IW'(t_next - TW'(gi));
    assign in_win = feed_next && (t_next >= TW'(gi)) && (t_next < TW'(gi + N));

    assign left_next[gi] = in_win ? a_mem[gi][k_idx] : '0;
    assign top_next[gi]  = in_win ? b_mem[k_idx][gi] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      t_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      clr_reg   <= 1'b0;
      en_reg    <= 1'b0;
      left_reg  <= '0;
      top_reg   <= '0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      clr_reg   <= clr_next;
      en_reg    <= en_next;
      left_reg  <= left_next;
      top_reg   <= top_next;
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign arr_clr = clr_reg;
  assign arr_en  = en_reg;
  assign in_left = left_reg;
  assign in_top  = top_reg;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: per-cycle scoreboard of control and stream
// outputs, plus a behavioural systolic array whose accumulators are checked against A x B.
module tb_systolic_feeder;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IW  = 2;
  localparam int CYC = 3 * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic wr_sel = 1'b0;
  logic [IW-1:0] wr_row = '0;
  logic [IW-1:0] wr_col = '0;
  logic [W-1:0]  wr_data = '0;
  logic start = 1'b0;
  logic busy, done, arr_clr, arr_en;
  logic [N-1:0][W-1:0] in_left, in_top;

  systolic_feeder #(.MATRIX_SIZE(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
    .busy(busy), .done(done), .arr_clr(arr_clr), .arr_en(arr_en),
    .in_left(in_left), .in_top(in_top)
  );

  always #5 clk = ~clk;

  int ma [N][N];
  int mb [N][N];
  int pa [N][N];
  int pb [N][N];
  int acc [N][N];

  typedef struct packed {
    logic busy;
    logic done;
    logic clr;
    logic en;
    logic [N-1:0][W-1:0] left;
    logic [N-1:0][W-1:0] top;
  } exp_t;

  exp_t exp_q[$];
  int   prod_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Behavioural output-stationary array fed by the DUT streams.
  always @(posedge clk) begin
    int a_in, b_in;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!rst_n || arr_clr) begin
          acc[i][j] <= 0;
          pa[i][j]  <= 0;
          pb[i][j]  <= 0;
        end else if (arr_en) begin
          a_in = (j == 0) ? int'(in_left[i]) : pa[i][j-1];
          b_in = (i == 0) ? int'(in_top[j]) : pb[i-1][j];
          acc[i][j] <= acc[i][j] + a_in * b_in;
          pa[i][j]  <= a_in;
          pb[i][j]  <= b_in;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {60'd0, busy, done, arr_clr, arr_en}, 64'd0);
    chk({tag, "_left"}, 64'(in_left), 64'd0);
    chk({tag, "_top"}, 64'(in_top), 64'd0);
  endtask

  task automatic wr(input logic sel, input int r, input int c, input int v);
    wr_en = 1'b1; wr_sel = sel; wr_row = IW'(r); wr_col = IW'(c); wr_data = W'(v);
    if (sel) mb[r][c] = v; else ma[r][c] = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  function automatic exp_t mk(input logic b, input logic d, input logic cl, input logic en, input int t);
    exp_t e;
    e = '0;
    e.busy = b; e.done = d; e.clr = cl; e.en = en;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = t - i;
        if (k >= 0 && k < N) begin
          e.left[i] = W'(ma[i][k]);
          e.top[i]  = W'(mb[k][i]);
        end
      end
    end
    return e;
  endfunction

  task automatic push_pass();
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 0));
    for (int t = 0; t <= CYC - 3; t++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, t));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0));
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
        prod_q.push_back(s);
      end
    end
  endtask

  task automatic check_rec(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_ctl"}, {60'd0, busy, done, arr_clr, arr_en}, {60'd0, e.busy, e.done, e.clr, e.en});
    chk({tag, "_left"}, 64'(in_left), 64'(e.left));
    chk({tag, "_top"}, 64'(in_top), 64'(e.top));
  endtask

  task automatic run_pass(input string name, input bit inject, input bit wr_start,
                          input bit start_on_done, input int abort_t, input bit check_t3);
    if (wr_start) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'd99;
      ma[0][0] = 99;
    end
    push_pass();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < CYC; c++) begin
      check_rec($sformatf("%s_c%0d", name, c));
      if (check_t3 && c == 4) chk({name, "_t3_left"}, 64'(in_left), 64'h0D0A0704);
      if (abort_t >= 0 && c == abort_t + 1) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle({name, "_rst"});
        rst_n = 1'b1;
        exp_q.delete(); prod_q.delete();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
        for (int d = 0; d < CYC; d++) begin
          @(negedge clk);
          chk($sformatf("%s_after%0d", name, d), {62'd0, busy, done}, 64'd0);
        end
        return;
      end
      if (c == CYC - 1) begin
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++)
          chk($sformatf("%s_acc%0d%0d", name, i, j), 64'(acc[i][j]), 64'(prod_q.pop_front()));
      end
      if (inject && c >= 1 && c <= CYC - 2) begin
        wr_en = 1'b1; wr_sel = c[0];
        wr_row = IW'($urandom_range(0, N - 1)); wr_col = IW'($urandom_range(0, N - 1));
        wr_data = 8'hEE; start = 1'b1;
      end else begin
        wr_en = 1'b0;
        start = start_on_done && (c == CYC - 1);
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk_idle({name, "_idle"});
    start = 1'b0;
    if (start_on_done) begin
      @(negedge clk);
      chk_idle({name, "_ignored"});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      wr(1'b0, i, j, i * N + j + 1);
      wr(1'b1, i, j, (i == j) ? 1 : 0);
    end
    run_pass("ident", 1'b0, 1'b0, 1'b1, -1, 1'b1);

    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wr(1'b1, i, j, 2);
    run_pass("twos_inj", 1'b1, 1'b0, 1'b0, -1, 1'b0);
    run_pass("twos_old", 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_pass("wrstart", 1'b0, 1'b1, 1'b0, -1, 1'b0);
    run_pass("abort", 1'b0, 1'b0, 1'b0, 5, 1'b0);
    run_pass("zero", 1'b0, 1'b0, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
